// File: rtl/parking_pkg.sv
// Shared types and default sizing for the parking-spot scan core.
package parking_pkg;

    localparam int P_NUM_SPOTS  = 64;
    localparam int P_ADDR_W     = 6;
    localparam int P_DATA_W     = 8;
    localparam int P_OCC_THRESH = 128;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } scan_state_t;

endpackage

// File: rtl/spot_scan_core_accum.sv
// Threshold compare, saturating free counter and first-free capture.
module spot_accum
    import parking_pkg::*;
#(
    parameter int NUM_SPOTS  = P_NUM_SPOTS,
    parameter int ADDR_W     = P_ADDR_W,
    parameter int DATA_W     = P_DATA_W,
    parameter int OCC_THRESH = P_OCC_THRESH
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clr,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_sample,
    input  logic [ADDR_W-1:0] i_idx,
    output logic [ADDR_W:0]   o_cnt,
    output logic [ADDR_W-1:0] o_first,
    output logic              o_first_vld,
    output logic [ADDR_W:0]   o_cnt_nxt,
    output logic [ADDR_W-1:0] o_first_nxt,
    output logic              o_first_vld_nxt
);

    localparam logic [DATA_W:0] THR  = (DATA_W+1)'(OCC_THRESH);
    localparam logic [ADDR_W:0] MAXC = (ADDR_W+1)'(NUM_SPOTS);

    logic [ADDR_W:0]   r_cnt;
    logic [ADDR_W-1:0] r_first;
    logic              r_first_vld;
    logic              w_free;
    logic [ADDR_W:0]   w_cnt_nxt;
    logic [ADDR_W-1:0] w_first_nxt;
    logic              w_first_vld_nxt;

    assign w_free = ({1'b0, i_sample} < THR);

    always_comb begin
        w_cnt_nxt       = r_cnt;
        w_first_nxt     = r_first;
        w_first_vld_nxt = r_first_vld;
        if (i_clr) begin
            w_cnt_nxt       = '0;
            w_first_nxt     = '0;
            w_first_vld_nxt = 1'b0;
        end else if (i_en && w_free) begin
            if (r_cnt != MAXC)
                w_cnt_nxt = r_cnt + 1'b1;
            // Only the lowest free index of a run is kept.
            if (!r_first_vld) begin
                w_first_nxt     = i_idx;
                w_first_vld_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt       <= '0;
            r_first     <= '0;
            r_first_vld <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_first     <= w_first_nxt;
            r_first_vld <= w_first_vld_nxt;
        end
    end

    assign o_cnt           = r_cnt;
    assign o_first         = r_first;
    assign o_first_vld     = r_first_vld;
    assign o_cnt_nxt       = w_cnt_nxt;
    assign o_first_nxt     = w_first_nxt;
    assign o_first_vld_nxt = w_first_vld_nxt;

endmodule

// File: rtl/spot_scan_core.sv
// Scans NUM_SPOTS occupancy samples and reports free count / first free spot.
module spot_scan_core
    import parking_pkg::*;
#(
    parameter int NUM_SPOTS  = P_NUM_SPOTS,
    parameter int ADDR_W     = P_ADDR_W,
    parameter int DATA_W     = P_DATA_W,
    parameter int OCC_THRESH = P_OCC_THRESH
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              ap_start,
    output logic              ap_idle,
    output logic              ap_ready,
    output logic              ap_done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W:0]   free_count,
    output logic [ADDR_W-1:0] first_free,
    output logic              first_free_vld
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_SPOTS - 1);

    scan_state_t       r_state;
    logic              r_rd_d1;
    logic [ADDR_W-1:0] r_addr_d1;
    logic              w_clr;
    logic [ADDR_W:0]   w_cnt;
    logic [ADDR_W-1:0] w_first;
    logic              w_first_vld;
    logic [ADDR_W:0]   w_cnt_nxt;
    logic [ADDR_W-1:0] w_first_nxt;
    logic              w_first_vld_nxt;

    assign w_clr = (r_state == S_IDLE) && ap_start;

    spot_accum #(
        .NUM_SPOTS  (NUM_SPOTS),
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .OCC_THRESH (OCC_THRESH)
    ) u_accum (
        .i_clk           (HCLK),
        .i_rst           (HRESET),
        .i_clr           (w_clr),
        .i_en            (r_rd_d1),
        .i_sample        (mem_rdata),
        .i_idx           (r_addr_d1),
        .o_cnt           (w_cnt),
        .o_first         (w_first),
        .o_first_vld     (w_first_vld),
        .o_cnt_nxt       (w_cnt_nxt),
        .o_first_nxt     (w_first_nxt),
        .o_first_vld_nxt (w_first_vld_nxt)
    );

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state        <= S_IDLE;
            r_rd_d1        <= 1'b0;
            r_addr_d1      <= '0;
            ap_idle        <= 1'b1;
            ap_ready       <= 1'b0;
            ap_done        <= 1'b0;
            mem_rd_en      <= 1'b0;
            mem_addr       <= '0;
            free_count     <= '0;
            first_free     <= '0;
            first_free_vld <= 1'b0;
        end else begin
            // Sample data returns one cycle after its read strobe.
            r_rd_d1   <= mem_rd_en;
            r_addr_d1 <= mem_addr;
            ap_ready  <= 1'b0;
            ap_done   <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (ap_start) begin
                        r_state   <= S_READ;
                        ap_idle   <= 1'b0;
                        mem_rd_en <= 1'b1;
                        mem_addr  <= '0;
                    end
                end
                S_READ: begin
                    if (mem_addr == LAST) begin
                        r_state   <= S_DRAIN;
                        mem_rd_en <= 1'b0;
                    end else begin
                        mem_addr <= mem_addr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    // Final sample lands on this edge, so latch next-state values.
                    r_state        <= S_DONE;
                    ap_done        <= 1'b1;
                    ap_ready       <= 1'b1;
                    free_count     <= w_cnt_nxt;
                    first_free     <= w_first_nxt;
                    first_free_vld <= w_first_vld_nxt;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    ap_idle <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    ap_idle <= 1'b1;
                end
            endcase
        end
    end

    logic w_unused;
    assign w_unused = ^{w_cnt, w_first, w_first_vld};

endmodule
